tone_gate_controller: RTL
=========================

// Module: tone_gate_controller
// PURPOSE
//   Sequences the mic-frequency measurement path: generates the counting gate window,
//   synchronizes and edge-detects the raw mic comparator input, and counts rising edges
//   per window. At window end it latches the result to hz, clears the counter and re-arms.
//   It sits between the Pmod mic input (JA1) and the robot's tone-response logic, and
//   replaces the free-running one-second strobe with a single controlled sequencer.
// PARAMETERS
//   GATE_CYCLES  100_000_000  clk cycles per gate window (1 s at 100 MHz)
//   CNT_W        10           width of the edge counter and of the hz output
//   LO_HZ        400          lower in-band bound, inclusive, in counts per window
//   HI_HZ        600          upper in-band bound, inclusive, in counts per window
// PORTS
//   clk       in   1      100 MHz system clock
//   rst_n     in   1      asynchronous active-low reset
//   enable    in   1      level; 1 = run continuous windows, 0 = idle
//   sig_in    in   1      raw mic comparator signal (JA1), asynchronous to clk
//   hz        out  CNT_W  edge count of the last completed window
//   hz_valid  out  1      one-cycle pulse when hz updates
//   overflow  out  1      last completed window saturated the counter
//   in_band   out  1      LO_HZ <= hz <= HI_HZ for the last completed window
//   busy      out  1      1 while in the GATE state
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE. All outputs, counters and sync flops = 0.
//   Input path: 2-flop synchronizer, then 1 history flop.
//     rise = s2 & ~s3, so rise occurs 3 clk after the sig_in edge. There is no debounce.
//   FSM:
//     IDLE : gate_cnt=0, edge_cnt=0. enable=1 -> GATE on the next cycle.
//     GATE : gate_cnt increments each cycle. On rise, edge_cnt increments.
//            edge_cnt saturates at 2^CNT_W-1 and sets an internal sat flag.
//            When gate_cnt==GATE_CYCLES-1 -> LATCH. A rise on this cycle is counted.
//            enable=0 -> IDLE (abort). Counters are cleared, no hz_valid, outputs hold.
//     LATCH: one cycle.
//            hz<=edge_cnt, overflow<=sat, in_band<=(edge_cnt>=LO_HZ && edge_cnt<=HI_HZ).
//            hz_valid=1. edge_cnt, gate_cnt and sat are cleared.
//            Next state is GATE if enable=1, else IDLE.
//            A rise during LATCH is dropped, giving one cycle of dead time per window.
//   Window period is GATE_CYCLES+1 clk. hz_valid is registered and high only in the cycle
//   after LATCH is entered (same cycle hz changes).
//   hz, overflow and in_band hold between updates. They are changed only by LATCH or reset.
//   busy = (state==GATE), registered with the state.
//   Simultaneous rise and abort: the abort wins and the edge is discarded.
//   Reset mid-window: immediate clear; the window is lost.
// TESTING (sim with GATE_CYCLES=1000, LO_HZ=40, HI_HZ=60 unless noted)
//   1. enable=1, sig_in square wave with period 20 clk
//      -> hz=50, in_band=1, overflow=0; hz_valid every 1001 clk.
//   2. sig_in constant 1 after the first rise
//      -> first window counts 1, next window hz=0, in_band=0.
//   3. CNT_W=4, sig_in period 10 clk
//      -> hz=15, overflow=1. Next window at period 100 clk -> hz=10, overflow=0.
//   4. enable drops at gate_cnt=500 -> busy=0 next clk, no hz_valid, hz keeps its prior value.
//      Re-enable -> first hz_valid 1002 clk later.
//   5. rst_n pulsed low mid-window -> all outputs 0 immediately, FSM in IDLE.
//   6. Single sig_in edge placed so rise lands on gate_cnt=999 -> counted (hz=1).
//      Edge landing in the LATCH cycle -> not counted in either window.

Source files
------------

// File: rtl/tone_gate_controller.sv
// Tone gate sequencer: synchronizes the mic comparator, counts rising edges
// per gate window and latches the count, overflow and in-band flags.
module tone_gate_controller #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 10,
   parameter int unsigned LO_HZ       = 400,
   parameter int unsigned HI_HZ       = 600
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] hz,
   output logic             hz_valid,
   output logic             overflow,
   output logic             in_band,
   output logic             busy
);

   localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [31:0]      LO        = 32'(LO_HZ);
   localparam logic [31:0]      HI        = 32'(HI_HZ);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GATE  = 2'd1;
   localparam logic [1:0] LATCH = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat;
   logic             s1;
   logic             s2;
   logic             s3;
   logic             rise;
   logic [31:0]      cnt_ext;
   logic             band_nxt;

   // two sync flops plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise     = s2 & ~s3;
   assign cnt_ext  = 32'(edge_cnt);
   assign band_nxt = (cnt_ext >= LO) && (cnt_ext <= HI);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (enable) state_nxt = GATE;
         end
         GATE: begin
            if (!enable)                   state_nxt = IDLE;
            else if (gate_cnt == GATE_LAST) state_nxt = LATCH;
         end
         LATCH: begin
            state_nxt = enable ? GATE : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
         hz       <= '0;
         hz_valid <= 1'b0;
         overflow <= 1'b0;
         in_band  <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt == GATE);
         hz_valid <= 1'b0;
         unique case (state)
            GATE: begin
               // an abort discards any rise arriving in the same cycle
               if (!enable) begin
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + 1'b1;
                  if (rise) begin
                     if (edge_cnt == CNT_MAX) sat <= 1'b1;
                     else                     edge_cnt <= edge_cnt + 1'b1;
                  end
               end
            end
            LATCH: begin
               hz       <= edge_cnt;
               overflow <= sat;
               in_band  <= band_nxt;
               hz_valid <= 1'b1;
               gate_cnt <= '0;
               edge_cnt <= '0;
               sat      <= 1'b0;
            end
            default: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               sat      <= 1'b0;
            end
         endcase
      end
   end

endmodule
